// File: rtl/ones_count_sequencer.sv
// Popcount sequencer: counts ones in a latched vector one chunk per clock, then holds the result for a handshake.
// Optional macro ONES_SEQ_THRESHOLD_EN adds threshold_i / above_threshold_o.
module ones_count_sequencer #(
  parameter  int INPUT_FEATURES = 8,
  parameter  int CHUNKS         = 4,
  localparam int TOTAL          = INPUT_FEATURES * CHUNKS,
  localparam int CW             = $clog2(TOTAL + 1)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [TOTAL-1:0] features_i,
`ifdef ONES_SEQ_THRESHOLD_EN
  input  logic [CW-1:0]    threshold_i,
  output logic             above_threshold_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    count_o,
  output logic             busy_o
);

  // state | meaning
  // IDLE  | waiting for a vector, in_ready_o high
  // COUNT | adding one chunk popcount per edge
  // DONE  | result presented, waiting for out_ready_i
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  state_t               state_q, state_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic [CW-1:0]        acc_q, acc_n;
  logic [TOTAL-1:0]     feat_q, feat_n;
  logic [CW-1:0]        count_q, count_n;
  logic [INPUT_FEATURES-1:0] chunk;
  logic [CW-1:0]        sum;
`ifdef ONES_SEQ_THRESHOLD_EN
  logic                 above_q, above_n;
`endif

  function automatic logic [CW-1:0] popcount(input logic [INPUT_FEATURES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < INPUT_FEATURES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign chunk = feat_q[idx_q*INPUT_FEATURES +: INPUT_FEATURES];
  assign sum   = acc_q + popcount(chunk);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    acc_n   = acc_q;
    feat_n  = feat_q;
    count_n = count_q;
`ifdef ONES_SEQ_THRESHOLD_EN
    above_n = above_q;
`endif
    if (abort_i) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            feat_n  = features_i;
            acc_n   = '0;
            idx_n   = '0;
            state_n = COUNT;
          end
        end
        COUNT: begin
          acc_n = sum;
          idx_n = idx_q + 1'b1;
          if (idx_q == IW'(CHUNKS - 1)) begin
            state_n = DONE;
            idx_n   = '0;
            count_n = sum;
`ifdef ONES_SEQ_THRESHOLD_EN
            above_n = (sum >= threshold_i);
`endif
          end
        end
        DONE: begin
          if (out_ready_i) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      feat_q  <= '0;
      count_q <= '0;
`ifdef ONES_SEQ_THRESHOLD_EN
      above_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      acc_q   <= acc_n;
      feat_q  <= feat_n;
      count_q <= count_n;
`ifdef ONES_SEQ_THRESHOLD_EN
      above_q <= above_n;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign count_o     = count_q;
`ifdef ONES_SEQ_THRESHOLD_EN
  assign above_threshold_o = above_q;
`endif

endmodule

// File: doc/ones_count_sequencer.md
ONES_COUNT_SEQUENCER -- requirements
Module: ones_count_sequencer

Interface
REQ-001 The block SHALL have parameter INPUT_FEATURES, default 8, the chunk width counted per cycle.
REQ-002 The block SHALL have parameter CHUNKS, default 4, the number of chunks per vector (CHUNKS >= 2).
REQ-003 The block SHALL derive TOTAL = INPUT_FEATURES*CHUNKS and CW = $clog2(TOTAL+1).
REQ-004 clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_ni  input  1  reset, asynchronous assertion, active-low.
REQ-006 abort_i  input  1  synchronous abort of the current operation.
REQ-007 in_valid_i  input  1  vector offered.
REQ-008 in_ready_o  output  1  block accepts a vector.
REQ-009 features_i  input  TOTAL  feature vector to count.
REQ-010 out_valid_o  output  1  result available.
REQ-011 out_ready_i  input  1  consumer takes the result.
REQ-012 count_o  output  CW  number of ones in the accepted vector.
REQ-013 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, COUNT and DONE.
REQ-015 in_ready_o SHALL equal (state==IDLE) and not depend combinationally on in_valid_i.
REQ-016 On an edge with state IDLE and in_valid_i=1 and abort_i=0: features_i latched, accumulator cleared, chunk index 0, state to COUNT.
REQ-017 Each edge in COUNT SHALL add the popcount of latched chunk [index*INPUT_FEATURES +: INPUT_FEATURES] to the accumulator and increment the index.
REQ-018 On the edge that adds chunk CHUNKS-1, state SHALL go to DONE; out_valid_o rises exactly CHUNKS edges after the accepting edge.
REQ-019 In DONE, out_valid_o=1 and count_o SHALL hold stable until an edge with out_ready_i=1, which returns state to IDLE.
REQ-020 A new vector SHALL NOT be accepted in the cycle the result is taken; the earliest next acceptance is one edge later (in_ready_o high in IDLE).
REQ-021 The accumulator SHALL be CW bits and cannot overflow (maximum TOTAL); no saturation logic.
REQ-022 abort_i=1 on any edge SHALL force state to IDLE, clear the index, leave count_o at its last value and suppress out_valid_o; abort_i has priority over accept, count and output handshake.
REQ-023 abort_i in IDLE with in_valid_i=1 SHALL block acceptance on that edge.
REQ-024 count_o SHALL only change on the edge entering DONE; outside DONE it SHALL hold the last completed result.
REQ-025 features_i changes while not IDLE SHALL have no effect on the result.

Reset
REQ-026 reset_ni low SHALL immediately force: state IDLE, index 0, accumulator 0, count_o 0, out_valid_o 0, busy_o 0, in_ready_o 1.
REQ-027 Reset mid-COUNT or in DONE SHALL discard the operation with no out_valid_o pulse after release.
REQ-028 After reset_ni rises, the first rising edge SHALL be able to accept a vector.

Configuration
REQ-029 Macro ONES_SEQ_THRESHOLD_EN, when defined, SHALL add input threshold_i (CW bits) and output above_threshold_o (1 bit).
REQ-030 With the macro, above_threshold_o SHALL be registered together with count_o as (result >= threshold_i sampled on the DONE-entry edge), reset value 0, held like count_o.
REQ-031 Without the macro, neither port SHALL exist and behaviour SHALL be otherwise identical.

Verification (INPUT_FEATURES=8, CHUNKS=4)
REQ-032 Accept 32'hFFFF_FFFF -> out_valid_o rises 4 edges after acceptance, count_o=32, busy_o high for those 4 cycles.
REQ-033 Accept 32'h8000_0001 then 32'h0000_0000 back-to-back with out_ready_i=1 -> results 2 then 0, second accept one edge after first result taken.
REQ-034 Accept 32'h0F0F_00FF, hold out_ready_i=0 for 10 cycles -> out_valid_o and count_o=16 stable throughout, in_ready_o=0, then IDLE one edge after out_ready_i=1.
REQ-035 abort_i=1 on second COUNT edge of 32'hFFFF_FFFF -> IDLE next edge, no out_valid_o, count_o keeps previous value; reset_ni low in DONE -> all outputs reset immediately.
REQ-036 With ONES_SEQ_THRESHOLD_EN, threshold_i=16: 32'h0000_FFFF -> above_threshold_o=1; 32'h0000_7FFF -> 0.
